// File: rtl/binarization_threshold_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the adaptive
// binarization threshold controller.
package binarization_threshold_ctrl_pkg;

  localparam int LUMA_W = 8;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DIV   = 2'd1,
    ST_APPLY = 2'd2
  } state_e;

  localparam int DEF_THRESH_C = 64;
  localparam int THRESH_MIN_C = 16;
  localparam int THRESH_MAX_C = 240;

  // Luma sum needs 8 extra bits over the pixel count to never overflow.
  function automatic int sum_width(input int pix_cnt_w);
    return pix_cnt_w + LUMA_W;
  endfunction

  // mean + signed offset, evaluated in 10 bits so neither end can wrap.
  function automatic logic [7:0] clamp_thresh(input logic [7:0] mean,
                                              input logic [7:0] offset,
                                              input logic [7:0] lo,
                                              input logic [7:0] hi);
    logic signed [9:0] cand;
    cand = $signed({2'b00, mean}) + $signed({{2{offset[7]}}, offset});
    if (cand < $signed({2'b00, lo})) begin
      return lo;
    end else if (cand > $signed({2'b00, hi})) begin
      return hi;
    end else begin
      return 8'(cand);
    end
  endfunction

endpackage

// File: rtl/binarization_threshold_ctrl_divider.sv
// Restoring sequential divider: one quotient bit per cycle, DIVIDEND_W cycles
// after start; the quotient output is saturated to QUO_W bits.
module seq_divider #(
  parameter int DIVIDEND_W = 30,
  parameter int DIVISOR_W  = 22,
  parameter int QUO_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  done,
  output logic [QUO_W-1:0]      quotient
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  den_q, den_d;
  logic [CNT_W-1:0]      iter_q, iter_d;
  logic                  run_q, run_d;
  logic [DIVISOR_W:0]    rem_shift;
  logic                  ge;

  always_comb begin
    rem_shift = {rem_q, quo_q[DIVIDEND_W-1]};
    ge        = rem_shift >= {1'b0, den_q};
    quo_d     = quo_q;
    rem_d     = rem_q;
    den_d     = den_q;
    iter_d    = iter_q;
    run_d     = run_q;
    if (start) begin
      quo_d  = dividend;
      rem_d  = '0;
      den_d  = divisor;
      iter_d = '0;
      run_d  = 1'b1;
    end else if (run_q) begin
      // Dividend bits shift out of the top as quotient bits shift in below.
      quo_d  = {quo_q[DIVIDEND_W-2:0], ge};
      rem_d  = ge ? DIVISOR_W'(rem_shift - {1'b0, den_q}) : rem_shift[DIVISOR_W-1:0];
      iter_d = iter_q + CNT_W'(1);
      if (iter_q == LAST_ITER) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      iter_q <= '0;
      run_q  <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      iter_q <= iter_d;
      run_q  <= run_d;
    end
  end

  assign done     = run_q && (iter_q == LAST_ITER);
  assign quotient = (|quo_q[DIVIDEND_W-1:QUO_W]) ? '1 : quo_q[QUO_W-1:0];

endmodule

// File: rtl/binarization_threshold_ctrl.sv
// Frame-adaptive threshold controller: accumulates luma per frame, divides
// during blanking and publishes a clamped threshold at frame boundaries.
module binarization_threshold_ctrl
  import binarization_threshold_ctrl_pkg::*;
#(
  parameter int PIX_CNT_W  = 22,
  parameter int DEF_THRESH = DEF_THRESH_C,
  parameter int THRESH_MIN = THRESH_MIN_C,
  parameter int THRESH_MAX = THRESH_MAX_C
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ycbcr_vsync,
  input  logic       ycbcr_de,
  input  logic [7:0] luminance,
  input  logic       cfg_auto,
  input  logic [7:0] cfg_thresh,
  input  logic [7:0] cfg_offset,
  output logic [7:0] threshold,
  output logic       thresh_upd,
  output logic [7:0] mean_luma,
  output logic       busy,
  output logic       overrun
);

  localparam int SUM_W = sum_width(PIX_CNT_W);
  localparam logic [7:0] DEF_T = 8'(DEF_THRESH);
  localparam logic [7:0] MIN_T = 8'(THRESH_MIN);
  localparam logic [7:0] MAX_T = 8'(THRESH_MAX);

  state_e               state_q, state_d;
  logic                 vsync_q;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [PIX_CNT_W-1:0] cnt_q, cnt_d;
  logic                 auto_q, auto_d;
  logic [7:0]           threshold_q, threshold_d;
  logic [7:0]           mean_q, mean_d;
  logic                 upd_q, upd_d;
  logic                 overrun_q, overrun_d;

  logic       rise;
  logic       in_flight;
  logic       div_start;
  logic       div_done;
  logic [7:0] div_quo;

  assign rise      = ycbcr_vsync & ~vsync_q;
  assign in_flight = (state_q != ST_ACCUM);
  assign div_start = rise && !in_flight && (cnt_q != '0);

  seq_divider #(
    .DIVIDEND_W (SUM_W),
    .DIVISOR_W  (PIX_CNT_W),
    .QUO_W      (8)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (sum_q),
    .divisor  (cnt_q),
    .done     (div_done),
    .quotient (div_quo)
  );

  // A pixel on the rise cycle already belongs to the new frame.
  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (rise) begin
      sum_d = ycbcr_de ? SUM_W'(luminance) : '0;
      cnt_d = ycbcr_de ? PIX_CNT_W'(1) : '0;
    end else if (ycbcr_de && !(&cnt_q)) begin
      sum_d = sum_q + SUM_W'(luminance);
      cnt_d = cnt_q + PIX_CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: if (div_start) state_d = ST_DIV;
      ST_DIV:   if (div_done)  state_d = ST_APPLY;
      ST_APPLY: state_d = ST_ACCUM;
      default:  state_d = ST_ACCUM;
    endcase
  end

  always_comb begin
    busy        = in_flight;
    threshold_d = threshold_q;
    mean_d      = mean_q;
    upd_d       = 1'b0;
    auto_d      = div_start ? cfg_auto : auto_q;
    overrun_d   = overrun_q | (rise & in_flight);
    if (state_q == ST_APPLY) begin
      mean_d = div_quo;
      if (auto_q) begin
        threshold_d = clamp_thresh(div_quo, cfg_offset, MIN_T, MAX_T);
        upd_d       = 1'b1;
      end
    end
    if (rise && !cfg_auto) begin
      threshold_d = cfg_thresh;
      upd_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      vsync_q     <= 1'b0;
      sum_q       <= '0;
      cnt_q       <= '0;
      auto_q      <= 1'b1;
      threshold_q <= DEF_T;
      mean_q      <= '0;
      upd_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= ycbcr_vsync;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      auto_q      <= auto_d;
      threshold_q <= threshold_d;
      mean_q      <= mean_d;
      upd_q       <= upd_d;
      overrun_q   <= overrun_d;
    end
  end

  assign threshold  = threshold_q;
  assign thresh_upd = upd_q;
  assign mean_luma  = mean_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_binarization_threshold_ctrl.sv
// Self-checking bench: frame-level behavioural model compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_binarization_threshold_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       de = 1'b0;
  logic [7:0] lum = '0;
  logic       cfg_auto = 1'b1;
  logic [7:0] cfg_thresh = '0;
  logic [7:0] cfg_offset = '0;
  logic [7:0] threshold;
  logic       thresh_upd;
  logic [7:0] mean_luma;
  logic       busy;
  logic       overrun;

  binarization_threshold_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ycbcr_vsync (vsync),
    .ycbcr_de    (de),
    .luminance   (lum),
    .cfg_auto    (cfg_auto),
    .cfg_thresh  (cfg_thresh),
    .cfg_offset  (cfg_offset),
    .threshold   (threshold),
    .thresh_upd  (thresh_upd),
    .mean_luma   (mean_luma),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int upd_cnt = 0;

  // Frame-level model: a result computed at a frame boundary lands 31 edges later.
  int     m_thresh = 64;
  int     m_mean = 0;
  bit     m_upd = 0;
  bit     m_over = 0;
  bit     m_vs_prev = 0;
  longint m_sum = 0;
  longint m_cnt = 0;
  bit     pending = 0;
  int     pend_mean = 0;
  bit     pend_auto = 0;
  longint cyc = 0;
  longint apply_at = 0;
  bit     was_busy;
  bit     m_rise;

  function automatic int model_clamp(int mean, logic [7:0] off);
    int v;
    v = mean + (off[7] ? int'(off) - 256 : int'(off));
    if (v < 16) return 16;
    if (v > 240) return 240;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_thresh = 64; m_mean = 0; m_upd = 0; m_over = 0; m_vs_prev = 0;
      m_sum = 0; m_cnt = 0; pending = 0;
    end else begin
      cyc++;
      was_busy = pending;
      m_rise = vsync && !m_vs_prev;
      m_vs_prev = vsync;
      m_upd = 0;
      if (pending && cyc == apply_at) begin
        m_mean = pend_mean;
        if (pend_auto) begin
          m_thresh = model_clamp(pend_mean, cfg_offset);
          m_upd = 1;
        end
        pending = 0;
      end
      if (m_rise) begin
        if (was_busy) m_over = 1;
        else if (m_cnt != 0) begin
          pending = 1;
          pend_mean = (m_sum / m_cnt > 255) ? 255 : int'(m_sum / m_cnt);
          pend_auto = cfg_auto;
          apply_at = cyc + 31;
        end
        if (!cfg_auto) begin
          m_thresh = int'(cfg_thresh);
          m_upd = 1;
        end
        m_sum = de ? longint'(lum) : 0;
        m_cnt = de ? 1 : 0;
      end else if (de && m_cnt < 64'd4194303) begin
        m_sum += longint'(lum);
        m_cnt++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    chk("threshold", int'(threshold), m_thresh);
    chk("mean_luma", int'(mean_luma), m_mean);
    chk("thresh_upd", int'(thresh_upd), int'(m_upd));
    chk("busy", int'(busy), int'(pending));
    chk("overrun", int'(overrun), int'(m_over));
    if (busy) busy_cnt++;
    if (thresh_upd) upd_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  // mode 0: constant base, 1: ramp 0..n-1, 2: random
  task automatic frame(input int n, input int mode, input int base);
    for (int i = 0; i < n; i++) begin
      de = 1'b1;
      lum = (mode == 0) ? 8'(base) : (mode == 1) ? 8'(i) : 8'($urandom_range(0, 255));
      tick();
    end
    de = 1'b0;
    tick();
  endtask

  task automatic rise_wait(input int n);
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (n - 3) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  int busy_base, upd_base;

  initial begin
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("lit_reset_thresh", int'(threshold), 64);
    chk("lit_reset_busy", int'(busy), 0);

    // Auto, offset 0, 16 x 100
    frame(16, 0, 100);
    busy_base = busy_cnt; upd_base = upd_cnt;
    rise_wait(32);
    chk("lit_auto100_thresh", int'(threshold), 100);
    chk("lit_auto100_mean", int'(mean_luma), 100);
    repeat (8) tick();
    chk("lit_auto100_busy_cycles", busy_cnt - busy_base, 31);
    chk("lit_auto100_upd_pulses", upd_cnt - upd_base, 1);

    cfg_offset = 8'hEC;
    frame(16, 0, 100);
    rise_wait(40);
    chk("lit_offset_neg20", int'(threshold), 80);

    cfg_offset = 8'h00;
    frame(16, 1, 0);
    rise_wait(40);
    chk("lit_ramp_mean", int'(mean_luma), 7);
    chk("lit_ramp_clamp_lo", int'(threshold), 16);

    cfg_offset = 8'd10;
    frame(16, 0, 255);
    rise_wait(40);
    chk("lit_clamp_hi", int'(threshold), 240);

    // Manual mode
    cfg_offset = 8'h00;
    do_reset();
    cfg_auto = 1'b0;
    frame(8, 0, 30);
    cfg_thresh = 8'h80;
    frame(8, 0, 30);
    chk("lit_manual_hold", int'(threshold), 64);
    vsync = 1'b1;
    tick();
    chk("lit_manual_write", int'(threshold), 128);
    chk("lit_manual_pulse", int'(thresh_upd), 1);
    repeat (2) tick();
    vsync = 1'b0;
    repeat (40) tick();
    chk("lit_manual_keep", int'(threshold), 128);
    chk("lit_manual_mean", int'(mean_luma), 30);

    // Empty frame
    cfg_auto = 1'b1;
    frame(16, 0, 90);
    rise_wait(40);
    busy_base = busy_cnt; upd_base = upd_cnt;
    rise_wait(40);
    chk("lit_empty_thresh", int'(threshold), 90);
    chk("lit_empty_busy", busy_cnt - busy_base, 0);
    chk("lit_empty_upd", upd_cnt - upd_base, 0);

    // Overrun
    frame(16, 0, 50);
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    frame(4, 0, 200);
    repeat (2) tick();
    rise_wait(40);
    chk("lit_overrun_flag", int'(overrun), 1);
    chk("lit_overrun_first", int'(threshold), 50);
    frame(16, 0, 120);
    rise_wait(40);
    chk("lit_after_overrun", int'(threshold), 120);

    // Reset mid-divide
    frame(16, 0, 77);
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("lit_rst_div_thresh", int'(threshold), 64);
    chk("lit_rst_div_busy", int'(busy), 0);
    chk("lit_rst_div_overrun", int'(overrun), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    frame(16, 0, 200);
    rise_wait(40);
    chk("lit_after_rst", int'(threshold), 200);

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      cfg_auto   = ($urandom_range(0, 3) != 0);
      cfg_offset = 8'($urandom);
      cfg_thresh = 8'($urandom);
      frame($urandom_range(1, 60), 2, 0);
      rise_wait(40);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/binarization_threshold_ctrl.md
Name: binarization_threshold_ctrl

Overview:
Frame-adaptive threshold controller for the luminance binarization stage.
- Accumulates luminance statistics over each active frame.
- During vertical blanking, computes the frame mean luminance with a multi-cycle divider and adds a signed offset.
- Publishes a clamped 8-bit threshold that the binarizer compares against.
- A manual mode replaces the computed value with a software-set threshold. Either way, the threshold only changes at frame boundaries.

Parameters:
PIX_CNT_W, 22, pixel counter width (max 2^22-1 pixels per frame)
DEF_THRESH, 64, threshold after reset
THRESH_MIN, 16, lower clamp for the auto threshold
THRESH_MAX, 240, upper clamp for the auto threshold

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ycbcr_vsync  input  1  vertical sync, active high; rising edge = frame boundary
ycbcr_de  input  1  pixel valid
luminance  input  8  Y component, sampled when ycbcr_de=1
cfg_auto  input  1  1=adaptive threshold, 0=manual
cfg_thresh  input  8  manual threshold
cfg_offset  input  8  signed two's-complement offset added to the mean (auto only)
threshold  output  8  threshold for the binarizer
thresh_upd  output  1  one-cycle pulse when threshold is written
mean_luma  output  8  last computed frame mean
busy  output  1  high in DIV and APPLY
overrun  output  1  sticky; set when a frame boundary arrives while busy

Behaviour:
- Reset (async, rst_n=0) values:
  - threshold=DEF_THRESH; mean_luma=0; thresh_upd=0; busy=0; overrun=0.
  - Accumulators cleared; state=ACCUM.
  - Reset mid-DIV abandons the division.
- Edge detect:
  - vsync_d is a registered copy of ycbcr_vsync.
  - rise = ycbcr_vsync & ~vsync_d, evaluated in the first cycle vsync is sampled high.
- Accumulation runs in every state:
  - Each cycle with de=1: sum += luminance and cnt += 1.
  - sum is SUM_W = PIX_CNT_W+8 bits.
  - When cnt reaches all-ones, both sum and cnt freeze for the rest of the frame (no wrap).
- On rise, in the same clock edge:
  - Snapshot sum/cnt into the divider registers.
  - Clear sum and cnt. A pixel with de=1 on the rise cycle counts toward the new frame.
- Manual mode (cfg_auto=0 sampled on rise):
  - threshold <= cfg_thresh on that edge; thresh_upd pulses the next cycle.
  - The divider still runs, so mean_luma stays current.
  - cfg_thresh changes mid-frame have no effect until the next rise.
- State machine:
  - ACCUM: idle. On rise with cnt snapshot != 0, go to DIV. With cnt snapshot == 0, stay in ACCUM; mean and threshold are unchanged and there is no pulse.
  - DIV: restoring divider, 1 quotient bit per cycle, exactly SUM_W cycles. quotient = floor(sum/cnt), saturated to 255. Then go to APPLY.
  - APPLY (1 cycle):
    - mean_luma <= quotient.
    - cand = signed 10-bit (mean + sext(cfg_offset)), clamped to [THRESH_MIN, THRESH_MAX].
    - If the auto flag latched at rise is 1: threshold <= cand and thresh_upd=1 on the next cycle.
    - Return to ACCUM.
- Latency: threshold changes SUM_W+2 clocks after the rise edge (32 with defaults). This must be shorter than vertical blanking.
- Rise while busy (DIV/APPLY):
  - overrun <= 1 (sticky until reset).
  - The current division completes normally.
  - The new frame's snapshot is discarded; its accumulators are still cleared.
- threshold is never written outside APPLY or a manual-mode rise, so it is stable for the whole active frame.
- cfg_offset is sampled in the APPLY cycle. cfg_auto is sampled at rise.

Decomposition:
- Shared package: SUM_W derivation; state encoding (ACCUM, DIV, APPLY); default threshold and clamp constants.
- Natural sub-module: seq_divider (restoring, parameter width, start/done handshake, quotient saturation), reusable by later statistics blocks.
- Edge detect, accumulators, FSM and clamp stay in the top level.

Test Plan:
- Auto, offset 0: a 16-pixel frame all Y=100, then vsync rise -> after 32 clocks threshold=100, mean_luma=100, one thresh_upd pulse, busy high for exactly 31 cycles.
- Auto, offset 0xEC (-20): the same frame -> threshold=80. Then offset 0, pixels Y=0..15 -> mean_luma=7, threshold clamped to 16. A frame of all Y=255 with offset +10 -> threshold 240.
- Manual: cfg_auto=0, cfg_thresh=0x80 written mid-frame -> threshold stays 64 until the next rise, becomes 128 on that edge, pulse next cycle.
- Empty frame: no de between two rises -> threshold and mean unchanged, no thresh_upd, busy stays 0.
- Overrun: second rise 10 cycles after the first -> overrun=1, the first result is applied, the second frame's stats are dropped. The following frame works normally.
- Reset mid-DIV: assert rst_n=0 at cycle 5 of DIV -> threshold=64 and busy=0 immediately. The next full frame of Y=200 -> threshold=200.
